// File: rtl/bullet_slot_scheduler.sv
// bullet_slot_scheduler: shared bullet slot pool allocator for two players with
// fire-key edge capture, per-player cooldown, live-bullet limit and
// round-robin arbitration. All state advances on the frame clock.
module bullet_slot_scheduler #(
  parameter int unsigned NSLOTS   = 4,
  parameter int unsigned MAX_LIVE = 2,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  input  logic                fire_req1,
  input  logic                fire_req2,
  input  logic [1:0]          dir1,
  input  logic [1:0]          dir2,
  input  logic [NSLOTS-1:0]   slot_done,
  output logic [NSLOTS-1:0]   launch,
  output logic [NSLOTS-1:0]   slot_active,
  output logic [NSLOTS-1:0]   slot_owner,
  output logic [2*NSLOTS-1:0] slot_dir,
  output logic [2:0]          live1,
  output logic [2:0]          live2,
  output logic                grant1,
  output logic                grant2
);

  localparam int unsigned CD_W   = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
  localparam int unsigned LIVE_W = 3;
  localparam int unsigned DIR_W  = 2 * NSLOTS;

  // Registered state
  logic              r_hist1, r_hist2;
  logic              r_pend1, r_pend2;
  logic [CD_W-1:0]   r_cd1, r_cd2;
  logic              r_rr;
  logic [NSLOTS-1:0] r_slot_active, r_slot_owner, r_launch;
  logic [DIR_W-1:0]  r_slot_dir;
  logic              r_grant1, r_grant2;

  // Next-state values
  logic              w_pend1_n, w_pend2_n;
  logic [CD_W-1:0]   w_cd1_n, w_cd2_n;
  logic              w_rr_n;
  logic [NSLOTS-1:0] w_slot_active_n, w_slot_owner_n, w_launch_n;
  logic [DIR_W-1:0]  w_slot_dir_n;

  // Decode / arbitration wires
  logic [LIVE_W-1:0] w_live1, w_live2;
  logic [NSLOTS-1:0] w_alloc_oh;
  logic              w_any_free;
  logic              w_elig1, w_elig2, w_win1, w_win2, w_win;
  logic              w_rise1, w_rise2;

  assign launch      = r_launch;
  assign slot_active = r_slot_active;
  assign slot_owner  = r_slot_owner;
  assign slot_dir    = r_slot_dir;
  assign grant1      = r_grant1;
  assign grant2      = r_grant2;
  assign live1       = w_live1;
  assign live2       = w_live2;

  // Per-player live-bullet popcount over registered slot state
  always_comb begin
    w_live1 = '0;
    w_live2 = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      w_live1 = w_live1 + LIVE_W'(r_slot_active[i] & ~r_slot_owner[i]);
      w_live2 = w_live2 + LIVE_W'(r_slot_active[i] &  r_slot_owner[i]);
    end
  end

  // Lowest-index free slot, one-hot; slots freed this cycle are not yet visible
  always_comb begin
    w_alloc_oh = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (!r_slot_active[i] && !w_any_free) begin
        w_alloc_oh[i] = 1'b1;
        w_any_free    = 1'b1;
      end
    end
  end

  // Eligibility and round-robin arbitration; r_rr names the last winner (1 = player 2)
  always_comb begin
    w_rise1 = fire_req1 & ~r_hist1;
    w_rise2 = fire_req2 & ~r_hist2;
    w_elig1 = r_pend1 && (r_cd1 == '0) && (w_live1 < LIVE_W'(MAX_LIVE)) && w_any_free;
    w_elig2 = r_pend2 && (r_cd2 == '0) && (w_live2 < LIVE_W'(MAX_LIVE)) && w_any_free;
    w_win1  = w_elig1 && (!w_elig2 || r_rr);
    w_win2  = w_elig2 && (!w_elig1 || !r_rr);
    w_win   = w_win1 | w_win2;
  end

  // Next-state computation for requests, cooldowns and slot pool
  always_comb begin
    w_pend1_n       = w_win1 ? 1'b0 : (r_pend1 | w_rise1);
    w_pend2_n       = w_win2 ? 1'b0 : (r_pend2 | w_rise2);
    w_cd1_n         = (r_cd1 != '0) ? (r_cd1 - CD_W'(1)) : '0;
    w_cd2_n         = (r_cd2 != '0) ? (r_cd2 - CD_W'(1)) : '0;
    w_rr_n          = r_rr;
    w_slot_active_n = r_slot_active & ~slot_done;
    w_slot_owner_n  = r_slot_owner;
    w_slot_dir_n    = r_slot_dir;
    w_launch_n      = '0;
    if (w_win1) begin
      w_cd1_n = CD_W'(COOLDOWN);
      w_rr_n  = 1'b0;
    end
    if (w_win2) begin
      w_cd2_n = CD_W'(COOLDOWN);
      w_rr_n  = 1'b1;
    end
    if (w_win) begin
      w_launch_n      = w_alloc_oh;
      w_slot_active_n = w_slot_active_n | w_alloc_oh;
      for (int i = 0; i < NSLOTS; i++) begin
        if (w_alloc_oh[i]) begin
          w_slot_owner_n[i]       = w_win2;
          w_slot_dir_n[2*i +: 2]  = w_win2 ? dir2 : dir1;
        end
      end
    end
  end

  // State registers; key history resets high so a held key cannot fire
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hist1       <= 1'b1;
      r_hist2       <= 1'b1;
      r_pend1       <= 1'b0;
      r_pend2       <= 1'b0;
      r_cd1         <= '0;
      r_cd2         <= '0;
      r_rr          <= 1'b1;
      r_slot_active <= '0;
      r_slot_owner  <= '0;
      r_slot_dir    <= '0;
      r_launch      <= '0;
      r_grant1      <= 1'b0;
      r_grant2      <= 1'b0;
    end else begin
      r_hist1       <= fire_req1;
      r_hist2       <= fire_req2;
      r_pend1       <= w_pend1_n;
      r_pend2       <= w_pend2_n;
      r_cd1         <= w_cd1_n;
      r_cd2         <= w_cd2_n;
      r_rr          <= w_rr_n;
      r_slot_active <= w_slot_active_n;
      r_slot_owner  <= w_slot_owner_n;
      r_slot_dir    <= w_slot_dir_n;
      r_launch      <= w_launch_n;
      r_grant1      <= w_win1;
      r_grant2      <= w_win2;
    end
  end

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// tb_bullet_slot_scheduler: directed self-checking bench for bullet_slot_scheduler.
module tb_bullet_slot_scheduler;

  logic       frame_clk;
  logic       Reset_n;
  logic       fire_req1, fire_req2;
  logic [1:0] dir1, dir2;
  logic [3:0] slot_done;
  logic [3:0] launch, slot_active, slot_owner;
  logic [7:0] slot_dir;
  logic [2:0] live1, live2;
  logic       grant1, grant2;

  int n_cmp = 0;
  int n_err = 0;

  bullet_slot_scheduler #(
    .NSLOTS   (4),
    .MAX_LIVE (2),
    .COOLDOWN (8)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .fire_req1   (fire_req1),
    .fire_req2   (fire_req2),
    .dir1        (dir1),
    .dir2        (dir2),
    .slot_done   (slot_done),
    .launch      (launch),
    .slot_active (slot_active),
    .slot_owner  (slot_owner),
    .slot_dir    (slot_dir),
    .live1       (live1),
    .live2       (live2),
    .grant1      (grant1),
    .grant2      (grant2)
  );

  // Frame clock
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and land on the following falling edge
  task automatic step();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  function automatic logic [31:0] own_m();
    return 32'(slot_owner & slot_active);
  endfunction

  initial begin
    Reset_n   = 1'b0;
    fire_req1 = 1'b1;
    fire_req2 = 1'b0;
    dir1      = 2'b00;
    dir2      = 2'b00;
    slot_done = 4'b0000;
    step();
    step();
    chk("rst_launch", 32'(launch), 32'h0);
    chk("rst_active", 32'(slot_active), 32'h0);
    chk("rst_owner", 32'(slot_owner), 32'h0);
    chk("rst_dir", 32'(slot_dir), 32'h0);
    chk("rst_live1", 32'(live1), 32'h0);
    chk("rst_live2", 32'(live2), 32'h0);
    chk("rst_grants", 32'({grant1, grant2}), 32'h0);

    // Key held through reset release must not fire
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_held_key", 32'({grant1, grant2, slot_active}), 32'h0);
    end

    // Single player 1 press
    fire_req1 = 1'b0;
    step();
    dir1 = 2'b01; fire_req1 = 1'b1;
    step();
    chk("p1_latency", 32'(grant1), 32'h0);
    fire_req1 = 1'b0;
    step();
    chk("p1_grant", 32'(grant1), 32'h1);
    chk("p1_grant2_idle", 32'(grant2), 32'h0);
    chk("p1_launch", 32'(launch), 32'h1);
    chk("p1_active", 32'(slot_active), 32'h1);
    chk("p1_owner", own_m(), 32'h0);
    chk("p1_dir", 32'(slot_dir), 32'h01);
    chk("p1_live1", 32'(live1), 32'h1);
    chk("p1_live2", 32'(live2), 32'h0);
    step();
    chk("p1_grant_pulse", 32'(grant1), 32'h0);
    chk("p1_launch_pulse", 32'(launch), 32'h0);
    chk("p1_active_hold", 32'(slot_active), 32'h1);

    // Second press 3 cycles after grant is buffered through cooldown
    step();
    fire_req1 = 1'b1; dir1 = 2'b11;
    step();
    fire_req1 = 1'b0; slot_done = 4'b1110;
    step();
    slot_done = 4'b0000;
    chk("done_inactive", 32'(slot_active), 32'h1);
    chk("p1_cd_hold", 32'(grant1), 32'h0);
    for (int i = 5; i <= 8; i++) begin
      step();
      chk("p1_cd_hold", 32'(grant1), 32'h0);
    end
    step();
    chk("p1_cd_grant", 32'(grant1), 32'h1);
    chk("p1_cd_launch", 32'(launch), 32'h2);
    chk("p1_cd_active", 32'(slot_active), 32'h3);
    chk("p1_cd_dir", 32'(slot_dir), 32'h0D);
    chk("p1_cd_live1", 32'(live1), 32'h2);

    // Third press blocked by the live limit until a player 1 slot is released
    fire_req1 = 1'b1;
    step();
    fire_req1 = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      step();
      chk("p1_live_limit", 32'(grant1), 32'h0);
    end
    slot_done = 4'b0001; dir1 = 2'b10;
    step();
    slot_done = 4'b0000;
    chk("p1_release_active", 32'(slot_active), 32'h2);
    chk("p1_release_live1", 32'(live1), 32'h1);
    chk("p1_release_nogrant", 32'(grant1), 32'h0);
    step();
    chk("p1_regrant", 32'(grant1), 32'h1);
    chk("p1_regrant_launch", 32'(launch), 32'h1);
    chk("p1_regrant_active", 32'(slot_active), 32'h3);
    chk("p1_regrant_dir", 32'(slot_dir), 32'h0E);

    // Asynchronous reset mid-operation kills live bullets at once
    Reset_n = 1'b0;
    #1;
    chk("async_rst_active", 32'(slot_active), 32'h0);
    chk("async_rst_launch", 32'(launch), 32'h0);
    chk("async_rst_live1", 32'(live1), 32'h0);
    step();
    Reset_n = 1'b1;
    step();

    // Simultaneous presses: player 1 wins the first tie, player 2 next cycle
    fire_req1 = 1'b1; fire_req2 = 1'b1; dir1 = 2'b10; dir2 = 2'b11;
    step();
    chk("tie_latency", 32'({grant1, grant2}), 32'h0);
    fire_req1 = 1'b0; fire_req2 = 1'b0;
    step();
    chk("tie1_grant1", 32'(grant1), 32'h1);
    chk("tie1_grant2", 32'(grant2), 32'h0);
    chk("tie1_launch", 32'(launch), 32'h1);
    step();
    chk("tie1_next_grant1", 32'(grant1), 32'h0);
    chk("tie1_next_grant2", 32'(grant2), 32'h1);
    chk("tie1_next_launch", 32'(launch), 32'h2);
    chk("tie1_next_active", 32'(slot_active), 32'h3);
    chk("tie1_next_owner", own_m(), 32'h2);
    chk("tie1_next_dir", 32'(slot_dir), 32'h0E);
    chk("tie1_next_live1", 32'(live1), 32'h1);
    chk("tie1_next_live2", 32'(live2), 32'h1);

    // Player 2 press held through its cooldown, lands in slot 2
    fire_req2 = 1'b1; dir2 = 2'b01;
    step();
    fire_req2 = 1'b0;
    chk("p2_cd_hold", 32'(grant2), 32'h0);
    for (int i = 4; i <= 10; i++) begin
      step();
      chk("p2_cd_hold", 32'(grant2), 32'h0);
    end
    step();
    chk("p2_cd_grant", 32'(grant2), 32'h1);
    chk("p2_cd_launch", 32'(launch), 32'h4);
    chk("p2_cd_active", 32'(slot_active), 32'h7);
    chk("p2_cd_owner", own_m(), 32'h6);
    chk("p2_cd_dir", 32'(slot_dir), 32'h1E);
    chk("p2_cd_live2", 32'(live2), 32'h2);

    // Player 1 fills the last slot
    fire_req1 = 1'b1; dir1 = 2'b11;
    step();
    fire_req1 = 1'b0;
    step();
    chk("fill_grant1", 32'(grant1), 32'h1);
    chk("fill_launch", 32'(launch), 32'h8);
    chk("fill_active", 32'(slot_active), 32'hF);
    chk("fill_owner", own_m(), 32'h6);
    chk("fill_dir", 32'(slot_dir), 32'hDE);
    chk("fill_live1", 32'(live1), 32'h2);
    chk("fill_live2", 32'(live2), 32'h2);

    // Pool full: player 2 stays pending until its slot 2 is released
    fire_req2 = 1'b1; dir2 = 2'b10;
    step();
    fire_req2 = 1'b0;
    for (int i = 15; i <= 20; i++) begin
      step();
      chk("full_hold", 32'({grant1, grant2}), 32'h0);
    end
    slot_done = 4'b0100;
    step();
    slot_done = 4'b0000;
    chk("full_free_active", 32'(slot_active), 32'hB);
    chk("full_free_live2", 32'(live2), 32'h1);
    chk("full_free_nogrant", 32'(grant2), 32'h0);
    step();
    chk("full_regrant2", 32'(grant2), 32'h1);
    chk("full_relaunch", 32'(launch), 32'h4);
    chk("full_reactive", 32'(slot_active), 32'hF);
    chk("full_redir", 32'(slot_dir), 32'hEE);

    // Player 1 alone takes slot 3, making player 1 the last winner
    slot_done = 4'b1000; fire_req1 = 1'b1; dir1 = 2'b01;
    step();
    slot_done = 4'b0000; fire_req1 = 1'b0;
    chk("rr_prep_active", 32'(slot_active), 32'h7);
    chk("rr_prep_nogrant", 32'(grant1), 32'h0);
    step();
    chk("rr_prep_grant1", 32'(grant1), 32'h1);
    chk("rr_prep_launch", 32'(launch), 32'h8);

    // Both pending while pool is full; simultaneous release makes a tie won by player 2
    fire_req1 = 1'b1; fire_req2 = 1'b1; dir1 = 2'b00; dir2 = 2'b11;
    step();
    fire_req1 = 1'b0; fire_req2 = 1'b0;
    chk("tie2_hold", 32'({grant1, grant2}), 32'h0);
    for (int i = 5; i <= 12; i++) begin
      step();
      chk("tie2_hold", 32'({grant1, grant2}), 32'h0);
    end
    slot_done = 4'b0101;
    step();
    slot_done = 4'b0000;
    chk("tie2_free_active", 32'(slot_active), 32'hA);
    chk("tie2_free_nogrant", 32'({grant1, grant2}), 32'h0);
    step();
    chk("tie2_grant2", 32'(grant2), 32'h1);
    chk("tie2_grant1", 32'(grant1), 32'h0);
    chk("tie2_launch", 32'(launch), 32'h1);
    chk("tie2_owner", own_m(), 32'h3);
    step();
    chk("tie2_next_grant1", 32'(grant1), 32'h1);
    chk("tie2_next_grant2", 32'(grant2), 32'h0);
    chk("tie2_next_launch", 32'(launch), 32'h4);
    chk("tie2_next_active", 32'(slot_active), 32'hF);
    chk("tie2_next_owner", own_m(), 32'h3);
    chk("tie2_next_dir", 32'(slot_dir), 32'h4F);
    chk("tie2_next_live1", 32'(live1), 32'h2);
    chk("tie2_next_live2", 32'(live2), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
